// File: rtl/port_rr_scheduler.sv
// Round-robin read scheduler: shares one output link among N_PORTS fifos,
// draining the granted fifo in bursts of up to MAX_BURST words.
module port_rr_scheduler #(
  parameter  int unsigned N_PORTS   = 4,
  parameter  int unsigned W_WIDTH   = 8,
  parameter  int unsigned MAX_BURST = 4,
  localparam int unsigned PW        = $clog2(N_PORTS),
  localparam int unsigned CW        = $clog2(MAX_BURST + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_PORTS-1:0]         fifo_empty_i,
  input  logic [N_PORTS*W_WIDTH-1:0] fifo_data_i,
  output logic [N_PORTS-1:0]         fifo_rd_en_o,
  input  logic                       out_ready_i,
  output logic                       out_valid_o,
  output logic [W_WIDTH-1:0]         out_data_o,
  output logic [PW-1:0]              out_port_o,
  output logic                       busy_o
);

  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  grant_q, grant_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           out_valid_q, out_valid_d;
  logic [PW-1:0]  out_port_q, out_port_d;

  logic           found;
  logic [PW-1:0]  pick;
  int unsigned    scan;
  logic           rd_go;
  logic [PW-1:0]  grant_nxt;

  // First non-empty port at or after ptr, wrapping modulo N_PORTS
  always_comb begin
    found = 1'b0;
    pick  = '0;
    scan  = 0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      scan = 32'(ptr_q) + k;
      if (scan >= N_PORTS) scan = scan - N_PORTS;
      if (!found && !fifo_empty_i[PW'(scan)]) begin
        found = 1'b1;
        pick  = PW'(scan);
      end
    end
  end

  // Read issue decision; never reads an empty fifo or exceeds the burst
  always_comb begin
    rd_go = (state_q == SERVE) && out_ready_i && !fifo_empty_i[grant_q] &&
            (cnt_q < CW'(MAX_BURST));
    fifo_rd_en_o = rd_go ? (N_PORTS'(1) << grant_q) : '0;
    grant_nxt    = (grant_q == PW'(N_PORTS - 1)) ? '0 : grant_q + PW'(1);
  end

  // Next-state logic for the IDLE/SERVE scheduler
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    out_valid_d = rd_go;
    out_port_d  = rd_go ? grant_q : out_port_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (rd_go) cnt_d = cnt_q + CW'(1);
        if ((rd_go && (cnt_q + CW'(1) == CW'(MAX_BURST))) || fifo_empty_i[grant_q]) begin
          state_d = IDLE;
          ptr_d   = grant_nxt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_port_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_port_q  <= out_port_d;
    end
  end

  // fifo data_out is registered, so the word read last cycle is on its slice now
  always_comb begin
    out_valid_o = out_valid_q;
    out_port_o  = out_port_q;
    busy_o      = (state_q == SERVE);
    out_data_o  = out_valid_q ? fifo_data_i[32'(out_port_q)*W_WIDTH +: W_WIDTH] : '0;
  end

endmodule
